// File: rtl/uart_defs.sv
`default_nettype none
//------------------------------------------------------------------
// uart_defs : shared UART state encoding and baud divisor math
// Rev 1.0
//------------------------------------------------------------------
package uart_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Clocks per 16x oversample tick; the receiver uses the same divisor.
  function automatic int calc_m(input int clk_freq, input int baud);
    return clk_freq / (16 * baud);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
//------------------------------------------------------------------
// uart_baud_tick : free-running mod-M counter, one-cycle tick at M-1
// Rev 1.0
//------------------------------------------------------------------
module uart_baud_tick #(
  parameter int M = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int              CW     = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0]   c_LAST = CW'(M - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (r_count == c_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
//------------------------------------------------------------------
// uart_tx_serializer : LSB-first UART transmitter, 16x oversampled
// Rev 1.0
//------------------------------------------------------------------
module uart_tx_serializer
  import uart_defs::*;
#(
  parameter int clk_freq = 50000000,
  parameter int baud     = 19200,
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam int            M         = calc_m(clk_freq, baud);
  localparam int            SW        = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam logic [SW-1:0] c_S_LAST  = SW'(15);
  localparam logic [SW-1:0] c_S_STOP  = SW'(SB_TICK - 1);
  localparam logic [2:0]    c_N_LAST  = 3'(DBIT - 1);

  generate
    if (M < 1 || DBIT < 5 || DBIT > 8 || SB_TICK < 1) begin : g_bad_cfg
      $error("uart_tx_serializer: invalid parameter configuration");
    end
  endgenerate

  uart_state_t   r_state, w_state_next;
  logic [SW-1:0] r_s, w_s_next;
  logic [2:0]    r_n, w_n_next;
  logic [7:0]    r_sr, w_sr_next;
  logic          r_tx, w_tx_next;
  logic          w_clr, w_tick, w_done;

  uart_baud_tick #(.M(M)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_sr    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_sr    <= w_sr_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_sr_next    = r_sr;
    w_clr        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wr) begin
          w_sr_next    = din;
          w_s_next     = '0;
          w_clr        = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_s == c_S_LAST) begin
            w_s_next     = '0;
            w_n_next     = '0;
            w_state_next = ST_DATA;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_s == c_S_LAST) begin
            w_s_next  = '0;
            w_sr_next = r_sr >> 1;
            if (r_n == c_N_LAST) begin
              w_state_next = ST_STOP;
            end else begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_s == c_S_STOP) begin
            w_done       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Line level is registered from the next state so tx moves with it.
    case (w_state_next)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = w_sr_next[0];
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign tx           = r_tx;
  assign tx_busy      = (r_state != ST_IDLE);
  assign tx_done_tick = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
//------------------------------------------------------------------
// tb_uart_tx_serializer : directed self-checking bench, M=10 (160 clk/bit)
// Rev 1.0
//------------------------------------------------------------------
module tb_uart_tx_serializer;

  localparam int M   = 10;
  localparam int BIT = 16 * M;

  logic       clk;
  logic       rst;
  logic       r_wr, r_wr32;
  logic [7:0] r_din, r_din32;
  logic       w_tx16, w_busy16, w_done16;
  logic       w_tx32, w_busy32, w_done32;
  logic       r_sel;
  logic       w_tx, w_busy, w_done;

  int n_tests;
  int n_fail;

  uart_tx_serializer #(.clk_freq(3200), .baud(20), .DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .rst(rst), .wr(r_wr), .din(r_din),
    .tx(w_tx16), .tx_busy(w_busy16), .tx_done_tick(w_done16)
  );

  uart_tx_serializer #(.clk_freq(3200), .baud(20), .DBIT(8), .SB_TICK(32)) dut32 (
    .clk(clk), .rst(rst), .wr(r_wr32), .din(r_din32),
    .tx(w_tx32), .tx_busy(w_busy32), .tx_done_tick(w_done32)
  );

  assign w_tx   = r_sel ? w_tx32   : w_tx16;
  assign w_busy = r_sel ? w_busy32 : w_busy16;
  assign w_done = r_sel ? w_done32 : w_done16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the first sample where tx is low; walks the whole frame.
  task automatic watch_frame(input logic [7:0] e, input int sb, input int chg_at,
                             input logic [7:0] chg_val, output int wave_err,
                             output int done_at, output int done_cnt);
    int   total;
    logic ex;
    total    = 9 * BIT + sb * M;
    wave_err = 0;
    done_at  = -1;
    done_cnt = 0;
    for (int i = 0; i < total; i++) begin
      if (i == chg_at) begin
        r_din   = chg_val;
        r_din32 = chg_val;
      end
      if (i < BIT)           ex = 1'b0;
      else if (i < 9 * BIT)  ex = e[(i - BIT) / BIT];
      else                   ex = 1'b1;
      if (w_tx !== ex || w_busy !== 1'b1) wave_err++;
      if (w_done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic rx_decode(output logic [7:0] b, output logic ok);
    logic found;
    found = 1'b0;
    b     = '0;
    for (int k = 0; k < 4000 && !found; k++) begin
      if (w_tx === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    ok = found;
    if (found) begin
      repeat (BIT / 2) @(negedge clk);
      if (w_tx !== 1'b0) ok = 1'b0;
      for (int j = 0; j < 8; j++) begin
        repeat (BIT) @(negedge clk);
        b[j] = w_tx;
      end
      repeat (BIT) @(negedge clk);
      if (w_tx !== 1'b1) ok = 1'b0;
      for (int k = 0; k < 400 && w_busy === 1'b1; k++) @(negedge clk);
    end
  endtask

  initial begin
    int         err, dat, dcnt, cnt;
    logic [7:0] rb;
    logic       ok;
    logic [7:0] loop_vals [3];
    n_tests = 0;
    n_fail  = 0;
    r_sel   = 1'b0;
    rst     = 1'b1;
    r_wr    = 1'b0;
    r_wr32  = 1'b0;
    r_din   = 8'h00;
    r_din32 = 8'h00;
    loop_vals[0] = 8'h00;
    loop_vals[1] = 8'hFF;
    loop_vals[2] = 8'h55;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx",   {31'd0, w_tx16},   32'd1);
    check("rst_busy", {31'd0, w_busy16}, 32'd0);
    check("rst_done", {31'd0, w_done16}, 32'd0);
    check("rst_tx32", {31'd0, w_tx32},   32'd1);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (w_tx16 !== 1'b1 || w_busy16 !== 1'b0 || w_done16 !== 1'b0) cnt++;
    end
    check("idle_500", cnt, 0);

    // Single frame 0xA5
    r_din = 8'hA5;
    r_wr  = 1'b1;
    @(negedge clk);
    r_wr  = 1'b0;
    check("a5_fall", {31'd0, w_tx16}, 32'd0);
    watch_frame(8'hA5, 16, -1, 8'h00, err, dat, dcnt);
    check("a5_wave",    err,  0);
    check("a5_done_at", dat,  1599);
    check("a5_done_n",  dcnt, 1);
    check("a5_end_tx",   {31'd0, w_tx16},   32'd1);
    check("a5_end_busy", {31'd0, w_busy16}, 32'd0);

    // wr held high, din changes mid-frame
    repeat (20) @(negedge clk);
    r_din = 8'h3C;
    r_wr  = 1'b1;
    @(negedge clk);
    check("b2b_fall1", {31'd0, w_tx16}, 32'd0);
    watch_frame(8'h3C, 16, 700, 8'hFF, err, dat, dcnt);
    check("b2b_wave1",   err, 0);
    check("b2b_done1",   dat, 1599);
    check("b2b_gap_tx",  {31'd0, w_tx16},   32'd1);
    check("b2b_gap_bsy", {31'd0, w_busy16}, 32'd0);
    @(negedge clk);
    r_wr = 1'b0;
    check("b2b_fall2", {31'd0, w_tx16}, 32'd0);
    watch_frame(8'hFF, 16, -1, 8'h00, err, dat, dcnt);
    check("b2b_wave2", err, 0);
    check("b2b_done2", dat, 1599);

    // Two stop bits on the second instance
    repeat (20) @(negedge clk);
    r_sel   = 1'b1;
    r_din32 = 8'h00;
    r_wr32  = 1'b1;
    @(negedge clk);
    r_wr32  = 1'b0;
    check("sb32_fall", {31'd0, w_tx32}, 32'd0);
    watch_frame(8'h00, 32, -1, 8'h00, err, dat, dcnt);
    check("sb32_wave",   err,  0);
    check("sb32_done",   dat,  1759);
    check("sb32_done_n", dcnt, 1);
    r_sel = 1'b0;

    // Reset during data bit 3
    repeat (20) @(negedge clk);
    r_din = 8'h55;
    r_wr  = 1'b1;
    @(negedge clk);
    r_wr  = 1'b0;
    cnt   = 0;
    for (int i = 0; i < 4 * BIT + 60; i++) begin
      if (w_done16 === 1'b1) cnt++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tx",   {31'd0, w_tx16},   32'd1);
    check("mid_rst_busy", {31'd0, w_busy16}, 32'd0);
    for (int i = 0; i < 200; i++) begin
      if (w_done16 === 1'b1 || w_tx16 !== 1'b1) cnt++;
      @(negedge clk);
    end
    check("mid_rst_quiet", cnt, 0);
    r_din = 8'h55;
    r_wr  = 1'b1;
    @(negedge clk);
    r_wr  = 1'b0;
    watch_frame(8'h55, 16, -1, 8'h00, err, dat, dcnt);
    check("post_rst_wave", err, 0);
    check("post_rst_done", dat, 1599);

    // Loopback through a bench-side mid-bit sampling receiver
    for (int v = 0; v < 3; v++) begin
      repeat (10) @(negedge clk);
      r_din = loop_vals[v];
      r_wr  = 1'b1;
      @(negedge clk);
      r_wr  = 1'b0;
      rx_decode(rb, ok);
      check("loop_ok",   {31'd0, ok}, 32'd1);
      check("loop_data", {24'd0, rb}, {24'd0, loop_vals[v]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
